// File: rtl/bcd_subtractor_if.sv
// Operand/result bundle for the digit-serial BCD subtractor.
// Carries the start request, packed-BCD operands and the registered results.
// master drives start/x/y; slave (the subtractor) drives diff/borrow/busy/done/err.
interface bcd_subtractor_if #(
   parameter int DIGITS = 4
);
   logic                start;
   logic [4*DIGITS-1:0] x;
   logic [4*DIGITS-1:0] y;
   logic [4*DIGITS-1:0] diff;
   logic                borrow;
   logic                busy;
   logic                done;
   logic                err;

   modport master (
      output start, x, y,
      input  diff, borrow, busy, done, err
   );

   modport slave (
      input  start, x, y,
      output diff, borrow, busy, done, err
   );
endinterface

// File: rtl/bcd_subtractor.sv
// Digit-serial packed-BCD subtractor x - y, one digit per clock, LSD first.
// Latency: DIGITS cycles from accepting start to the done pulse; one op per DIGITS+2 cycles.
// No backpressure: start is sampled only in IDLE and ignored otherwise. Optional check: BCD_CHECK_EN.
module bcd_subtractor #(
   parameter int DIGITS = 4
) (
   input logic             clk,
   input logic             rst_n,
   bcd_subtractor_if.slave bus
);
   localparam int W  = 4 * DIGITS;
   localparam int IW = $clog2(DIGITS + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [W-1:0]   xs;
   logic [W-1:0]   ys;
   logic [W-1:0]   res;
   logic [W-1:0]   res_shift;
   logic           b;
   logic [IW-1:0]  idx;
   logic [3:0]     xd;
   logic [3:0]     yd;
   logic [4:0]     t;
   logic [3:0]     dig;
   logic           b_nxt;
   logic           last;
   logic           accept;

   // Per-digit arithmetic on the low digit of the operand shift registers.
   assign xd        = xs[3:0];
   assign yd        = ys[3:0];
   assign t         = {1'b0, xd} - {1'b0, yd} - {4'd0, b};
   assign b_nxt     = t[4];
   assign dig       = t[4] ? (t[3:0] + 4'd10) : t[3:0];
   // New digit enters at the top so the LSD ends up at bits [3:0] after DIGITS steps.
   assign res_shift = W'({dig, res} >> 4);
   assign last      = (idx == IW'(DIGITS - 1));
   assign accept    = (state == IDLE) && bus.start;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: DONE always lasts exactly one cycle, so start there is dropped.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last)      state_nxt = DONE;
         DONE:                   state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Status outputs decoded straight from the state register.
   always_comb begin
      bus.busy = (state == RUN);
      bus.done = (state == DONE);
   end

   // Operand capture, digit loop and result publication on the last digit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xs         <= '0;
         ys         <= '0;
         res        <= '0;
         b          <= 1'b0;
         idx        <= '0;
         bus.diff   <= '0;
         bus.borrow <= 1'b0;
      end else if (accept) begin
         xs  <= bus.x;
         ys  <= bus.y;
         res <= '0;
         b   <= 1'b0;
         idx <= '0;
      end else if (state == RUN) begin
         xs  <= xs >> 4;
         ys  <= ys >> 4;
         res <= res_shift;
         b   <= b_nxt;
         idx <= idx + 1'b1;
         if (last) begin
            bus.diff   <= res_shift;
            bus.borrow <= b_nxt;
         end
      end
   end

`ifdef BCD_CHECK_EN
   logic bad_acc;
   logic bad_dig;

   assign bad_dig = (xd > 4'd9) || (yd > 4'd9);

   // Accumulate any non-decimal digit seen during RUN; publish it with the result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bad_acc <= 1'b0;
         bus.err <= 1'b0;
      end else if (accept) begin
         bad_acc <= 1'b0;
      end else if (state == RUN) begin
         bad_acc <= bad_acc | bad_dig;
         if (last) bus.err <= bad_acc | bad_dig;
      end
   end
`else
   assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_subtractor.sv
// Directed bench for bcd_subtractor (DIGITS=4) with immediate-assertion checks.
// Inputs driven and outputs sampled on the falling edge, away from the active edge.
// Expected values are hand-computed ten's-complement BCD differences.
module tb_bcd_subtractor;
   localparam int DIGITS = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [15:0] last_diff;

   bcd_subtractor_if #(.DIGITS(DIGITS)) bus ();

   bcd_subtractor #(.DIGITS(DIGITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at the negedge right after the accepting edge; returns edges until done.
   task automatic wait_done(output int n, output int busy_n, output bit held);
      n      = 0;
      busy_n = 0;
      held   = 1'b1;
      while (bus.done !== 1'b1 && n < 20) begin
         if (bus.busy === 1'b1) busy_n++;
         if (bus.diff !== last_diff) held = 1'b0;
         @(posedge clk);
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_op(input logic [15:0] xv, input logic [15:0] yv,
                         input logic [15:0] dexp, input logic bexp, input logic eexp,
                         input string tag);
      int n;
      int busy_n;
      bit held;
      bus.x     = xv;
      bus.y     = yv;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.x     = 16'(($urandom));
      bus.y     = 16'(($urandom));
      wait_done(n, busy_n, held);
      chk({tag, "_latency"}, n, DIGITS);
      chk({tag, "_busy_cycles"}, busy_n, DIGITS);
      chk({tag, "_held"}, {31'd0, held}, 32'd1);
      chk({tag, "_diff"}, bus.diff, dexp);
      chk({tag, "_borrow"}, bus.borrow, bexp);
      chk({tag, "_err"}, bus.err, eexp);
      chk({tag, "_busy_at_done"}, bus.busy, 0);
      last_diff = dexp;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_done_drop"}, bus.done, 0);
   endtask

   initial begin
      int  n;
      int  busy_n;
      bit  held;
      int  ndone;
      logic exp_err;

      checks    = 0;
      errors    = 0;
      last_diff = 16'h0000;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.x     = 16'h0000;
      bus.y     = 16'h0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_diff", bus.diff, 0);
      chk("rst_borrow", bus.borrow, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(16'h1234, 16'h0567, 16'h0667, 1'b0, 1'b0, "basic");
      run_op(16'h0000, 16'h0001, 16'h9999, 1'b1, 1'b0, "under");
      run_op(16'h5000, 16'h0001, 16'h4999, 1'b0, 1'b0, "chain");
      run_op(16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, "equal");
      run_op(16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b0, "after_eq");
      run_op(16'h0372, 16'h0845, 16'h9527, 1'b1, 1'b0, "mixed");

      // start held high: operands in RUN/DONE must be ignored.
      bus.x     = 16'h0100;
      bus.y     = 16'h0001;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.x = 16'h3333;
      bus.y = 16'h2222;
      wait_done(n, busy_n, held);
      chk("hold_a_latency", n, DIGITS);
      chk("hold_a_diff", bus.diff, 16'h0099);
      chk("hold_a_borrow", bus.borrow, 0);
      last_diff = 16'h0099;
      bus.x = 16'h7777;
      bus.y = 16'h1111;
      @(posedge clk);
      @(negedge clk);
      wait_done(n, busy_n, held);
      chk("hold_b_spacing", n + 1, DIGITS + 2);
      chk("hold_b_held", {31'd0, held}, 32'd1);
      chk("hold_b_diff", bus.diff, 16'h6666);
      last_diff = 16'h6666;
      bus.start = 1'b0;
      ndone = 0;
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done === 1'b1) ndone++;
      end
      chk("hold_no_extra_done", ndone, 0);
      chk("hold_idle_busy", bus.busy, 0);

      // Reset in the middle of RUN aborts the operation.
      bus.x     = 16'h1234;
      bus.y     = 16'h0567;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_busy", bus.busy, 0);
      chk("abort_diff", bus.diff, 0);
      chk("abort_borrow", bus.borrow, 0);
      chk("abort_done", bus.done, 0);
      rst_n = 1'b1;
      last_diff = 16'h0000;
      ndone = 0;
      repeat (8) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done === 1'b1) ndone++;
      end
      chk("abort_no_done", ndone, 0);
      run_op(16'h2000, 16'h0001, 16'h1999, 1'b0, 1'b0, "post_abort");

`ifdef BCD_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      run_op(16'h12A4, 16'h0001, 16'h12A3, 1'b0, exp_err, "invalid");
      run_op(16'h0042, 16'h0021, 16'h0021, 1'b0, 1'b0, "err_clear");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
